// File: rtl/alu_acc_if.sv
// alu_acc_if: operand, control, result and decrementer signals of the accumulator ALU core.
interface alu_acc_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] ab_d, bb_d, dec_in, ab, bb, aluresult, aluout, dec_out;
    logic             ab_en, bb_en, carry_en, cout, carry, zero, dec_wrap;
    logic [2:0]       alucontrol;
    modport master (
        output ab_d, ab_en, bb_d, bb_en, alucontrol, carry_en, dec_in,
        input  ab, bb, aluresult, cout, aluout, carry, zero, dec_out, dec_wrap
    );
    modport slave (
        input  ab_d, ab_en, bb_d, bb_en, alucontrol, carry_en, dec_in,
        output ab, bb, aluresult, cout, aluout, carry, zero, dec_out, dec_wrap
    );
endinterface

// File: rtl/alu_acc_core.sv
// alu_acc_core: gated operand buffers, 8-op ALU with registered result/carry,
// and a wrap-around decrementer for stack-pointer pushes.
module alu_acc_core #(
    parameter int WIDTH = 8
) (
    input logic   clk,
    input logic   reset,
    alu_acc_if.slave bus
);
    logic [WIDTH-1:0] ab, bb, aluout_q, aluout_d;
    logic [WIDTH:0]   sum;
    logic             carry_q, carry_d;
    assign ab = bus.ab_en ? bus.ab_d : '0;
    assign bb = bus.bb_en ? bus.bb_d : '0;
    // Bit WIDTH of sum is the carry, or the borrow for SUB (9-bit wrap of a negative difference).
    always_comb begin
        sum = '0;
        case (bus.alucontrol)
            3'b000:  sum = {1'b0, ab & bb};
            3'b001:  sum = {1'b0, ab | bb};
            3'b010:  sum = {1'b0, ab} + {1'b0, bb};
            3'b011:  sum = {1'b0, ab} - {1'b0, bb};
            3'b100:  sum = {1'b0, ab ^ bb};
            3'b101:  sum = {1'b0, ~ab};
            3'b110:  sum = {1'b0, ab} + (WIDTH+1)'(1);
            default: sum = {1'b0, bb};
        endcase
    end
    assign aluout_d = sum[WIDTH-1:0];
    assign carry_d  = bus.carry_en ? sum[WIDTH] : carry_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aluout_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            aluout_q <= aluout_d;
            carry_q  <= carry_d;
        end
    end
    assign bus.ab        = ab;
    assign bus.bb        = bb;
    assign bus.aluresult = sum[WIDTH-1:0];
    assign bus.cout      = sum[WIDTH];
    assign bus.aluout    = aluout_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = (ab == '0);
    assign bus.dec_out   = bus.dec_in - WIDTH'(1);
    assign bus.dec_wrap  = (bus.dec_in == '0);
endmodule

// File: tb/tb_alu_acc_core.sv
// tb_alu_acc_core: directed vectors with literal checks plus a per-cycle
// comparison against an integer-arithmetic model of the ALU core.
module tb_alu_acc_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    logic [7:0] m_aluout = 8'h00;
    logic       m_carry = 1'b0;

    alu_acc_if #(.WIDTH(8)) bus();

    alu_acc_core #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Returns {cout, result} from plain integer arithmetic.
    function automatic logic [8:0] alu_model(input logic [2:0] op, input int a, input int b);
        int r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a + b;
            3'd3: r = (a < b ? 256 : 0) + ((a - b + 256) % 256);
            3'd4: r = a ^ b;
            3'd5: r = 255 - a;
            3'd6: r = a + 1;
            default: r = b;
        endcase
        return r[8:0];
    endfunction

    function automatic int op_a();
        return bus.ab_en ? int'(bus.ab_d) : 0;
    endfunction

    function automatic int op_b();
        return bus.bb_en ? int'(bus.bb_d) : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register model: result captured every edge, carry only when enabled, cleared by reset.
    always @(posedge clk) begin
        if (!reset) begin
            m_aluout = 8'h00;
            m_carry  = 1'b0;
        end else begin
            logic [8:0] r;
            r = alu_model(bus.alucontrol, op_a(), op_b());
            m_aluout = r[7:0];
            if (bus.carry_en) m_carry = r[8];
        end
    end

    always @(negedge reset) begin
        m_aluout = 8'h00;
        m_carry  = 1'b0;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [8:0] r;
                logic [7:0] d;
                r = alu_model(bus.alucontrol, op_a(), op_b());
                d = 8'((int'(bus.dec_in) + 255) % 256);
                chk("m_ab", bus.ab, 32'(op_a()));
                chk("m_bb", bus.bb, 32'(op_b()));
                chk("m_aluresult", bus.aluresult, 32'(r[7:0]));
                chk("m_cout", bus.cout, 32'(r[8]));
                chk("m_aluout", bus.aluout, 32'(m_aluout));
                chk("m_carry", bus.carry, 32'(m_carry));
                chk("m_zero", bus.zero, 32'(op_a() == 0));
                chk("m_dec_out", bus.dec_out, 32'(d));
                chk("m_dec_wrap", bus.dec_wrap, 32'(bus.dec_in == 8'h00));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic ae, input logic [7:0] a, input logic be, input logic [7:0] b,
                         input logic [2:0] op, input logic ce);
        bus.ab_en = ae; bus.ab_d = a; bus.bb_en = be; bus.bb_d = b;
        bus.alucontrol = op; bus.carry_en = ce;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 8'h00, 3'b000, 1'b0);
        bus.dec_in = 8'h10;
        step(); step();
        chk_en = 1'b1;
        chk("rst_aluout", bus.aluout, 32'h00);
        chk("rst_carry", bus.carry, 32'h0);
        reset = 1'b1;

        drive(1'b1, 8'hF0, 1'b1, 8'h20, 3'b010, 1'b1);
        #1;
        chk("add_res", bus.aluresult, 32'h10);
        chk("add_cout", bus.cout, 32'h1);
        step();
        chk("add_aluout", bus.aluout, 32'h10);
        chk("add_carry", bus.carry, 32'h1);

        drive(1'b1, 8'h00, 1'b1, 8'h5A, 3'b111, 1'b0);
        step();
        chk("pre_rst_aluout", bus.aluout, 32'h5A);
        chk("pre_rst_carry", bus.carry, 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_aluout", bus.aluout, 32'h00);
        chk("async_rst_carry", bus.carry, 32'h0);
        bus.carry_en = 1'b1;
        step();
        chk("held_rst_aluout", bus.aluout, 32'h00);
        reset = 1'b1;
        bus.carry_en = 1'b0;
        step();
        chk("resume_aluout", bus.aluout, 32'h5A);

        drive(1'b1, 8'h05, 1'b1, 8'h07, 3'b011, 1'b1);
        #1;
        chk("sub_borrow_res", bus.aluresult, 32'hFE);
        chk("sub_borrow_cout", bus.cout, 32'h1);
        step();
        drive(1'b1, 8'h07, 1'b1, 8'h05, 3'b011, 1'b1);
        #1;
        chk("sub_res", bus.aluresult, 32'h02);
        chk("sub_cout", bus.cout, 32'h0);
        step();
        chk("sub_carry", bus.carry, 32'h0);

        drive(1'b1, 8'h05, 1'b1, 8'h07, 3'b011, 1'b1);
        step();
        chk("carry_set", bus.carry, 32'h1);
        drive(1'b1, 8'hFF, 1'b1, 8'h0F, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("carry_hold", bus.carry, 32'h1);
        end
        bus.carry_en = 1'b1;
        step();
        chk("carry_clear", bus.carry, 32'h0);

        drive(1'b0, 8'h3C, 1'b1, 8'h11, 3'b111, 1'b0);
        #1;
        chk("gate_ab", bus.ab, 32'h00);
        chk("gate_zero", bus.zero, 32'h1);
        chk("gate_res", bus.aluresult, 32'h11);
        bus.bb_en = 1'b0;
        #1;
        chk("gate_bb", bus.bb, 32'h00);
        step();

        bus.dec_in = 8'h68;
        #1;
        chk("dec_68", bus.dec_out, 32'h67);
        chk("dec_68_wrap", bus.dec_wrap, 32'h0);
        step();
        bus.dec_in = 8'h00;
        #1;
        chk("dec_00", bus.dec_out, 32'hFF);
        chk("dec_00_wrap", bus.dec_wrap, 32'h1);
        step();
        bus.dec_in = 8'h01;
        #1;
        chk("dec_01", bus.dec_out, 32'h00);
        chk("dec_01_wrap", bus.dec_wrap, 32'h0);
        step();

        drive(1'b1, 8'hFF, 1'b1, 8'h00, 3'b110, 1'b1);
        #1;
        chk("inc_wrap_res", bus.aluresult, 32'h00);
        chk("inc_wrap_cout", bus.cout, 32'h1);
        step();
        drive(1'b1, 8'hA5, 1'b1, 8'h3C, 3'b101, 1'b1);
        #1;
        chk("not_res", bus.aluresult, 32'h5A);
        step();

        for (int op = 0; op < 8; op++) begin
            drive(1'b1, 8'hC3, 1'b1, 8'h5A, 3'(op), 1'(op % 2));
            step();
            drive(1'b1, 8'h5A, 1'b1, 8'hC3, 3'(op), 1'b1);
            step();
        end
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
            bus.dec_in = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            step();
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
